// File: rtl/fetch_if.sv
// Fetch-side bundle: instruction-memory address/return, redirect input, decode handshake and fault report.
// master = fetch_unit, slave = memory/decode/branch environment.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_error;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc, fault, fault_pc,
        input  imem_data, imem_error, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc, fault, fault_pc,
        output imem_data, imem_error, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// PC owner + in-order fetch buffer; a fetch at edge N appears on inst_* after edge N.
// Full buffer stalls the PC without looking at inst_ready; imem_error parks fetch in FAULT until redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]    state;
    logic [31:0]   pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          fault_q;
    logic [31:0]   fault_pc_q;

    logic [31:0]   pc_buf   [DEPTH];
    logic [31:0]   data_buf [DEPTH];

    logic can_fetch;
    logic push;
    logic pop;
    logic take_fault;
    logic not_empty;

    // Fetch eligibility depends only on registered state, so inst_ready never reaches imem_addr.
    assign not_empty  = (count != '0);
    assign can_fetch  = (state == ST_RUN) && (count != FULL_CNT);
    assign push       = !bus.redirect_valid && can_fetch && !bus.imem_error;
    assign take_fault = !bus.redirect_valid && can_fetch &&  bus.imem_error;
    assign pop        = !bus.redirect_valid && not_empty && bus.inst_ready;

    assign bus.imem_addr  = pc;
    assign bus.inst_valid = not_empty;
    assign bus.inst_data  = not_empty ? data_buf[rd_ptr] : 32'h0;
    assign bus.inst_pc    = not_empty ? pc_buf[rd_ptr]   : 32'h0;
    assign bus.fault      = fault_q;
    assign bus.fault_pc   = fault_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else if (bus.redirect_valid) begin
            state   <= ST_RUN;
            pc      <= bus.redirect_pc;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            fault_q <= 1'b0;
        end else begin
            if (take_fault) begin
                state      <= ST_FAULT;
                fault_q    <= 1'b1;
                fault_pc_q <= pc;
            end
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]   <= pc;
            data_buf[wr_ptr] <= bus.imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1024-word combinational instruction-memory model.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] mem [1024];

    fetch_if bus();

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.imem_error = (bus.imem_addr[1:0] != 2'b00) || (bus.imem_addr[31:12] != 20'h0);
        bus.imem_data  = bus.imem_error ? 32'h0 : mem[bus.imem_addr[11:2]];
    end

    task automatic start_from_reset(input logic ready);
        @(negedge clk);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = ready;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic ready);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        bus.inst_ready     = ready;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b fault=%b fault_pc=%h required 0/0/0",
                     bus.inst_valid, bus.fault, bus.fault_pc);
        end
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h inst_pc=%h inst_data=%h required all 0",
                     bus.imem_addr, bus.inst_pc, bus.inst_data);
        end
    endtask

    task automatic test_stream;
        start_from_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i) || bus.inst_data !== mem[i]
                || bus.fault !== 1'b0) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b pc=%h data=%h fault=%b required 1/%h/%h/0",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_data, bus.fault, 32'(4*i), mem[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        start_from_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h00500093) begin
                failures++;
                $display("FAIL stall_hold_%0d: valid=%b pc=%h data=%h required 1/0/00500093",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_data);
            end
        end
        checks++;
        if (bus.imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL stall_addr: got %h required 00000008", bus.imem_addr);
        end
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i) || bus.inst_data !== mem[i]) begin
                failures++;
                $display("FAIL drain_%0d: valid=%b pc=%h data=%h required 1/%h/%h",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_data, 32'(4*i), mem[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_full;
        start_from_reset(1'b0);
        repeat (3) @(negedge clk);
        do_redirect(32'h40, 1'b1);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redirect_bubble: valid=%b addr=%h required 0/00000040",
                     bus.inst_valid, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_data !== 32'h1000_0010) begin
            failures++;
            $display("FAIL redirect_target: valid=%b pc=%h data=%h required 1/00000040/10000010",
                     bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
    endtask

    task automatic test_misaligned;
        do_redirect(32'h42, 1'b1);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pre: valid=%b fault=%b required 0/0", bus.inst_valid, bus.fault);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h42 || bus.inst_valid !== 1'b0
                || bus.imem_addr !== 32'h42) begin
                failures++;
                $display("FAIL misalign_fault_%0d: fault=%b fault_pc=%h valid=%b addr=%h required 1/42/0/42",
                         i, bus.fault, bus.fault_pc, bus.inst_valid, bus.imem_addr);
            end
        end
        do_redirect(32'h0, 1'b1);
        checks++;
        if (bus.fault !== 1'b0 || bus.inst_valid !== 1'b0 || bus.fault_pc !== 32'h42) begin
            failures++;
            $display("FAIL fault_clear: fault=%b valid=%b fault_pc=%h required 0/0/00000042",
                     bus.fault, bus.inst_valid, bus.fault_pc);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h00500093) begin
            failures++;
            $display("FAIL refetch_zero: valid=%b pc=%h data=%h required 1/0/00500093",
                     bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
    endtask

    task automatic test_boundary;
        do_redirect(32'hFFC, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFC || bus.inst_data !== 32'hDEAD_BEEF
            || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL last_word: valid=%b pc=%h data=%h fault=%b required 1/ffc/deadbeef/0",
                     bus.inst_valid, bus.inst_pc, bus.inst_data, bus.fault);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h1000 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL oob_fault: fault=%b fault_pc=%h valid=%b required 1/00001000/0",
                     bus.fault, bus.fault_pc, bus.inst_valid);
        end
    endtask

    task automatic test_async_reset;
        do_redirect(32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b0 || bus.imem_addr !== 32'h0
            || bus.inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b fault=%b addr=%h inst_pc=%h required 0/0/0/0",
                     bus.inst_valid, bus.fault, bus.imem_addr, bus.inst_pc);
        end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]    = 32'h0050_0093;
        mem[1]    = 32'h00a0_0113;
        mem[2]    = 32'h0020_81b3;
        mem[1023] = 32'hDEAD_BEEF;

        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_misaligned;
        test_boundary;
        test_async_reset;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
